// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_pkg : shared register-index type and architectural register ids   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int       NUM_REGS = 32;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd2;
  localparam reg_idx_t REG_A0   = 5'd10;
  localparam reg_idx_t REG_A7   = 5'd17;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard : per-register pending-write counters and busy    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int SB_W = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_valid,
  input  logic     issue_en_rd,
  input  reg_idx_t issue_rd,
  input  logic     wb_valid,
  input  logic     wb_en_rd,
  input  reg_idx_t wb_rd,
  input  logic     flush,
  input  reg_idx_t rs1_addr,
  input  reg_idx_t rs2_addr,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     sb_overflow
);

  localparam logic [SB_W-1:0] c_cnt_max = '1;
  localparam logic [SB_W-1:0] c_cnt_one = 1;

  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_ovf;
  logic [SB_W-1:0]     w_cnt [NUM_REGS];
  logic                r_sb_overflow;

  // Flush squashes the issuing instruction, so it never increments.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (issue_valid && issue_en_rd && !flush) w_inc[issue_rd] = 1'b1;
    if (wb_valid && wb_en_rd)                 w_dec[wb_rd]    = 1'b1;
    w_inc[REG_ZERO] = 1'b0;
    w_dec[REG_ZERO] = 1'b0;
  end

  assign w_cnt[0] = '0;
  assign w_ovf[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [SB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (w_inc[r] && !w_dec[r]) begin
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_one;
      end else if (w_dec[r] && !w_inc[r]) begin
        if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_one;
      end
    end

    assign w_cnt[r] = r_cnt;
    assign w_ovf[r] = w_inc[r] && !w_dec[r] && (r_cnt == c_cnt_max);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_sb_overflow <= 1'b0;
    else if (|w_ovf) r_sb_overflow <= 1'b1;
  end

  // A retiring write releases its own pending slot in the same cycle.
  function automatic logic busy_of(input logic [SB_W-1:0] cnt, input logic dec);
    return (cnt > c_cnt_one) || ((cnt == c_cnt_one) && !dec);
  endfunction

  assign rs1_busy    = busy_of(w_cnt[rs1_addr], w_dec[rs1_addr]);
  assign rs2_busy    = busy_of(w_cnt[rs2_addr], w_dec[rs2_addr]);
  assign sb_overflow = r_sb_overflow;

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile : integer register file, bypassed reads, a0-a7 taps          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile
  import rv_pkg::*;
#(
  parameter int              XLEN    = 64,
  parameter int              SB_W    = 2,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  reg_idx_t        rs1_addr,
  input  reg_idx_t        rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic            issue_en_rd,
  input  reg_idx_t        issue_rd,
  input  logic            wb_valid,
  input  logic            wb_en_rd,
  input  reg_idx_t        wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic [XLEN-1:0] a0,
  output logic [XLEN-1:0] a1,
  output logic [XLEN-1:0] a2,
  output logic [XLEN-1:0] a3,
  output logic [XLEN-1:0] a4,
  output logic [XLEN-1:0] a5,
  output logic [XLEN-1:0] a6,
  output logic [XLEN-1:0] a7,
  output logic            sb_overflow
);

  localparam int c_num_args = int'(REG_A7) - int'(REG_A0) + 1;

  logic            w_wr;
  logic [XLEN-1:0] w_x [NUM_REGS];
  logic [XLEN-1:0] w_a [c_num_args];

  assign w_wr          = wb_valid && wb_en_rd && (wb_rd != REG_ZERO);
  assign w_x[REG_ZERO] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_xreg
    localparam logic [XLEN-1:0] c_rst = (reg_idx_t'(r) == REG_SP) ? SP_INIT : '0;
    logic [XLEN-1:0] r_x;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            r_x <= c_rst;
      else if (w_wr && wb_rd == reg_idx_t'(r)) r_x <= wb_result;
    end

    assign w_x[r] = r_x;
  end

  always_comb begin
    rs1_data = w_x[rs1_addr];
    if (rs1_addr == REG_ZERO)           rs1_data = '0;
    else if (w_wr && wb_rd == rs1_addr) rs1_data = wb_result;
  end

  always_comb begin
    rs2_data = w_x[rs2_addr];
    if (rs2_addr == REG_ZERO)           rs2_data = '0;
    else if (w_wr && wb_rd == rs2_addr) rs2_data = wb_result;
  end

  // Ecall argument taps come straight from storage, without the bypass.
  for (genvar i = 0; i < c_num_args; i++) begin : g_atap
    assign w_a[i] = w_x[REG_A0 + reg_idx_t'(i)];
  end

  assign a0 = w_a[0];
  assign a1 = w_a[1];
  assign a2 = w_a[2];
  assign a3 = w_a[3];
  assign a4 = w_a[4];
  assign a5 = w_a[5];
  assign a6 = w_a[6];
  assign a7 = w_a[7];

  regfile_scoreboard #(
    .SB_W(SB_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_en_rd(issue_en_rd),
    .issue_rd   (issue_rd),
    .wb_valid   (wb_valid),
    .wb_en_rd   (wb_en_rd),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .sb_overflow(sb_overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile : directed table plus randomized run against a model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile;
  import rv_pkg::*;

  localparam int          XLEN    = 64;
  localparam int          SB_W    = 2;
  localparam logic [63:0] SP_INIT = 64'h8000;
  localparam int          CNT_MAX = (1 << SB_W) - 1;
  localparam logic [63:0] Z       = 64'h0;
  localparam logic [63:0] DEAD    = 64'hDEAD;
  localparam logic [63:0] SPV     = 64'h8000;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic [63:0]     rs1_data, rs2_data, wb_result;
  logic            rs1_busy, rs2_busy, issue_valid, issue_en_rd;
  logic            wb_valid, wb_en_rd, flush, sb_overflow;
  logic [63:0]     a0, a1, a2, a3, a4, a5, a6, a7;

  always #5 clk = ~clk;

  regfile #(.XLEN(XLEN), .SB_W(SB_W), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_en_rd(issue_en_rd), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_en_rd(wb_en_rd), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .sb_overflow(sb_overflow)
  );

  typedef struct {
    logic iv, ie; logic [4:0] ird;
    logic wv, we; logic [4:0] wrd; logic [63:0] wres;
    logic fl; logic [4:0] r1, r2;
    logic [63:0] e_d1, e_d2; logic e_b1, e_b2;
    logic [63:0] e_a0, e_a2; logic e_ovf;
  } vec_t;

  // Reference model: architectural register values and pending-write counts
  logic [63:0] mx [32];
  int          mc [32];
  logic        m_ovf;
  int          n_vec  = 0;
  int          n_miss = 0;
  vec_t        tbl [$];

  function automatic vec_t mk(int iv, int ie, int ird, int wv, int we, int wrd,
                              logic [63:0] wres, int fl, int r1, int r2,
                              logic [63:0] d1, logic [63:0] d2, int b1, int b2,
                              logic [63:0] ea0, logic [63:0] ea2, int ovf);
    vec_t v;
    v.iv = iv[0]; v.ie = ie[0]; v.ird = ird[4:0];
    v.wv = wv[0]; v.we = we[0]; v.wrd = wrd[4:0]; v.wres = wres;
    v.fl = fl[0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
    v.e_d1 = d1; v.e_d2 = d2; v.e_b1 = b1[0]; v.e_b2 = b2[0];
    v.e_a0 = ea0; v.e_a2 = ea2; v.e_ovf = ovf[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mx[i] = (i == 2) ? SP_INIT : 64'h0;
      mc[i] = 0;
    end
    m_ovf = 1'b0;
  endfunction

  function automatic logic m_wr();
    return wb_valid && wb_en_rd && (wb_rd != 5'd0);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'h0;
    if (m_wr() && wb_rd == a) return wb_result;
    return mx[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    int c;
    if (a == 5'd0) return 1'b0;
    c = mc[a];
    if (wb_valid && wb_en_rd && wb_rd == a) c = c - 1;
    if (c < 0) c = 0;
    return c != 0;
  endfunction

  function automatic void model_update();
    logic inc, dec;
    if (m_wr()) mx[wb_rd] = wb_result;
    if (flush) begin
      for (int r = 0; r < 32; r++) mc[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc = issue_valid && issue_en_rd && (int'(issue_rd) == r);
        dec = wb_valid && wb_en_rd && (int'(wb_rd) == r);
        if (inc && !dec) begin
          if (mc[r] == CNT_MAX) m_ovf = 1'b1;
          else mc[r] = mc[r] + 1;
        end else if (dec && !inc && mc[r] > 0) begin
          mc[r] = mc[r] - 1;
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " rs1_data"}, rs1_data, m_read(rs1_addr));
    chk({tag, " rs2_data"}, rs2_data, m_read(rs2_addr));
    chk({tag, " rs1_busy"}, 64'(rs1_busy), 64'(m_busy(rs1_addr)));
    chk({tag, " rs2_busy"}, 64'(rs2_busy), 64'(m_busy(rs2_addr)));
    chk({tag, " a0"}, a0, mx[10]);
    chk({tag, " a1"}, a1, mx[11]);
    chk({tag, " a2"}, a2, mx[12]);
    chk({tag, " a3"}, a3, mx[13]);
    chk({tag, " a4"}, a4, mx[14]);
    chk({tag, " a5"}, a5, mx[15]);
    chk({tag, " a6"}, a6, mx[16]);
    chk({tag, " a7"}, a7, mx[17]);
    chk({tag, " sb_overflow"}, 64'(sb_overflow), 64'(m_ovf));
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_en_rd = v.ie; issue_rd = v.ird;
    wb_valid = v.wv; wb_en_rd = v.we; wb_rd = v.wrd; wb_result = v.wres;
    flush = v.fl; rs1_addr = v.r1; rs2_addr = v.r2;
  endtask

  task automatic run_cycle(input vec_t v, input bit use_exp, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    check_model(tag);
    if (use_exp) begin
      chk({tag, " exp rs1_data"}, rs1_data, v.e_d1);
      chk({tag, " exp rs2_data"}, rs2_data, v.e_d2);
      chk({tag, " exp rs1_busy"}, 64'(rs1_busy), 64'(v.e_b1));
      chk({tag, " exp rs2_busy"}, 64'(rs2_busy), 64'(v.e_b2));
      chk({tag, " exp a0"}, a0, v.e_a0);
      chk({tag, " exp a2"}, a2, v.e_a2);
      chk({tag, " exp sb_overflow"}, 64'(sb_overflow), 64'(v.e_ovf));
    end
    @(posedge clk);
    model_update();
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    drive(mk(0,0,0, 0,0,0,Z, 0, 0,0, Z,Z,0,0, Z,Z,0));
    model_reset();

    //       iv ie ird wv we wrd wres          fl r1 r2  d1            d2 b1 b2 a0    a2            ovf
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0, 2, 5, SPV,          Z, 0, 0, Z,    Z,            0));
    tbl.push_back(mk(0,0,0, 1,1,10,DEAD,         0,10, 0, DEAD,         Z, 0, 0, Z,    Z,            0));
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0,10, 0, DEAD,         Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,0, 1,1,0, 64'h5,        0, 0, 0, Z,            Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,7, 0,0,0, Z,            0, 7, 0, Z,            Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,7, 0,0,0, Z,            0, 7, 0, Z,            Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0, 7, 0, Z,            Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(0,0,0, 1,1,7, 64'h11,       0, 7, 0, 64'h11,       Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(0,0,0, 1,1,7, 64'h22,       0, 7, 0, 64'h22,       Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0, 7, 0, 64'h22,       Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,3, 0,0,0, Z,            0, 3, 0, Z,            Z, 0, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,3, 0,0,0, Z,            0, 3, 0, Z,            Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,3, 0,0,0, Z,            0, 3, 0, Z,            Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(1,1,3, 0,0,0, Z,            0, 3, 0, Z,            Z, 1, 0, DEAD, Z,            0));
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0, 3, 0, Z,            Z, 1, 0, DEAD, Z,            1));
    tbl.push_back(mk(1,1,9, 1,1,12,64'h1234,     1,12, 3, 64'h1234,     Z, 0, 1, DEAD, Z,            1));
    tbl.push_back(mk(0,0,0, 0,0,0, Z,            0, 9, 3, Z,            Z, 0, 0, DEAD, 64'h1234,     1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Build pending state, then pull reset in the middle of a cycle.
    run_cycle(mk(1,1,5, 1,1,11,64'h77, 0, 5, 2, Z,Z,0,0, Z,Z,0), 1'b0, "pre_rst0");
    run_cycle(mk(1,1,5, 0,0,0, Z,      0, 5, 2, Z,Z,0,0, Z,Z,0), 1'b0, "pre_rst1");
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0,Z, 0, 5, 2, Z,Z,0,0, Z,Z,0));
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    chk("async_rst rs2_sp", rs2_data, SPV);
    chk("async_rst rs1_busy_x5", 64'(rs1_busy), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      v = mk(0,0,0, 0,0,0,Z, 0, 0,0, Z,Z,0,0, Z,Z,0);
      v.iv   = 1'($urandom_range(0, 1));
      v.ie   = ($urandom_range(0, 3) != 0);
      v.ird  = 5'($urandom_range(0, 7));
      v.wv   = 1'($urandom_range(0, 1));
      v.we   = ($urandom_range(0, 3) != 0);
      v.wrd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      v.wres = {$urandom, $urandom};
      v.fl   = ($urandom_range(0, 15) == 0);
      v.r1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.r2   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : v.wrd;
      run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile.md
# regfile

Integer register file for the in-order RISC-V pipeline. It receives the writeback stage's `result`/`rd`/`en_rd` write port and serves the two decode-stage read ports with same-cycle write bypass. It exports the registered a0–a7 values that writeback consumes for ecall dispatch. A per-register pending-write scoreboard lets decode stall on RAW hazards until the producing instruction retires through writeback.

## Interface
Parameters:
- `XLEN`, 64, data width.
- `SB_W`, 2, scoreboard counter width per register; maximum in-flight writes per register is 2^SB_W−1.
- `SP_INIT`, 64'h0, reset value of x2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rs1_addr`, `rs2_addr`  in  5  decode read addresses.
- `rs1_data`, `rs2_data`  out  XLEN  read data, combinational, write-bypassed.
- `rs1_busy`, `rs2_busy`  out  1  register has an outstanding write not retiring this cycle.
- `issue_valid`  in  1  decode issues an instruction this cycle.
- `issue_en_rd`  in  1  issued instruction writes rd.
- `issue_rd`  in  5  destination of the issued instruction.
- `wb_valid`  in  1  WB holds a non-bubble instruction completing this cycle.
- `wb_en_rd`  in  1  WB instruction writes rd.
- `wb_rd`  in  5  WB destination.
- `wb_result`  in  XLEN  WB write data.
- `flush`  in  1  squash all instructions younger than WB.
- `a0`..`a7`  out  XLEN each  registered contents of x10..x17.
- `sb_overflow`  out  1  sticky error: issue attempted on a saturated counter.

## Operation
- Write: `wr = wb_valid & wb_en_rd & (wb_rd != 0)`. On `wr`, x[wb_rd] ← wb_result at the clock edge. Writes to x0 are discarded; x0 always reads 0.
- Read: `rsN_data` = 0 if `rsN_addr == 0`; else `wb_result` if `wr` and `wb_rd == rsN_addr`; else x[rsN_addr].
- Scoreboard: counter `cnt[r]` for r = 1..31; cnt[0] is constant 0.
  - `inc[r] = issue_valid & issue_en_rd & issue_rd == r & !flush`.
  - `dec[r] = wb_valid & wb_en_rd & wb_rd == r`.
  - inc only → +1. If the counter is already at max, it holds and `sb_overflow` is set.
  - dec only → −1, saturating at 0.
  - inc and dec together → unchanged.
  - `flush` → all counters cleared to 0; flush overrides inc and dec. The WB write itself still occurs.
- Busy: `rsN_busy = (cnt[rsN_addr] − dec[rsN_addr]) != 0`, evaluated with a 0 floor. x0 is never busy.
- a0..a7 are driven directly from the x10..x17 storage and are not bypassed. They therefore show the pre-write values while an ecall is stalled in WB.
- `sb_overflow` stays set until reset.

## Timing
- Reset (reset == 0, asynchronous): x2 ← SP_INIT, all other registers 0, all counters 0, `sb_overflow` 0. Outputs after reset: a0..a7 = 0; busy = 0; `rsN_data` = 0, or SP_INIT when the address is 2 and no bypass is active.
- Reset deassertion is sampled synchronously by the first following `clk` edge.
- Read latency is 0 cycles, combinational from the address and bypass inputs.
- A write issued at edge N becomes visible in storage and on a0..a7 after edge N. It is visible through the bypass during the cycle before edge N.
- Busy reflects issues from prior cycles only. An issue in cycle N makes the register busy from cycle N+1.
- A reset asserted mid-operation discards all pending scoreboard state immediately.

## Structure
- Shared package `rv_pkg`:
  - `reg_idx_t` (logic [4:0]).
  - Constants `NUM_REGS = 32`, `REG_ZERO = 0`, `REG_SP = 2`, `REG_A0 = 10`, `REG_A7 = 17`.
- Sub-module `regfile_scoreboard`: holds counters, inc/dec/flush logic, busy lookup for 2 ports, and `sb_overflow`. The data array, bypass, and a0–a7 taps stay in `regfile`.

## Test plan
- Reset with SP_INIT = 64'h8000: read x2 → 64'h8000, read x5 → 0, a0..a7 = 0, busy = 0.
- WB writes x10 = 64'hDEAD while rs1_addr = 10: rs1_data = 64'hDEAD in the same cycle; a0 = 64'hDEAD only from the next cycle.
- WB writes x0 = 5: rs1_addr = 0 still reads 0, and x0 is never busy.
- Issue rd = 7 twice on consecutive cycles, then retire two WB writes to x7: busy sequence is 1, 1, 1, then 0 in the second WB cycle via dec lookahead.
- Issue rd = 3 three times, then a fourth issue with SB_W = 2: counter holds at 3 and `sb_overflow` is 1 from the next cycle.
- Issue rd = 9 with `flush` asserted together with a WB write to x12: x12 is updated, cnt[9] = 0, and all busy = 0 afterwards. Then assert reset mid-sequence: all state clears asynchronously.
